// File: rtl/sar_adc_pkg.sv
// Shared types and the code-to-voltage transfer function used by both the
// SAR ADC trial comparator and the DAC model, so the pair always agree.
`timescale 1ns/1ps
package sar_adc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } sar_state_t;

    // Ideal DAC transfer function: code * vref / 2^n, no rounding.
    function automatic real code_to_volt(input int code, input int n, input real vref);
        return real'(code) * vref / (2.0 ** n);
    endfunction

endpackage

// File: rtl/sar_trial_cmp.sv
// Real-valued trial comparator: decides whether the current trial bit is kept
// by comparing the held input voltage against the DAC level of the trial code.
`timescale 1ns/1ps
module sar_trial_cmp
    import sar_adc_pkg::*;
#(
    parameter int  N    = 3,
    parameter real VREF = 1.0
) (
    input  logic [N-1:0] trial,
    input  real          vin_s,
    output logic         keep
);

    // Keep the trial bit when the sampled input reaches the trial level.
    assign keep = (vin_s >= code_to_volt(int'(trial), N, VREF));

endmodule

// File: rtl/sar_adc.sv
// Successive-approximation ADC model: samples VIN on START, resolves one bit
// per clock MSB first, and publishes the code on Q with a one-cycle DONE.
`timescale 1ns/1ps
module sar_adc
    import sar_adc_pkg::*;
#(
    parameter int  N    = 3,
    parameter real VREF = 1.0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  real          VIN,
    output logic [N-1:0] Q,
    output logic         BUSY,
    output logic         DONE
);

    localparam int            IW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] IDX_MSB = IW'(N - 1);

    sar_state_t    state_q, state_d;
    logic [N-1:0]  trial_q, trial_d;
    logic [IW-1:0] idx_q, idx_d;
    real           vin_s_q, vin_s_d;
    logic [N-1:0]  q_d;
    logic          busy_d;
    logic          done_d;
    logic          keep;
    logic [N-1:0]  idx_bit;

    // One-hot mask of the bit currently under trial.
    assign idx_bit = N'(1) << idx_q;

    sar_trial_cmp #(
        .N    (N),
        .VREF (VREF)
    ) u_cmp (
        .trial (trial_q),
        .vin_s (vin_s_q),
        .keep  (keep)
    );

    // Next-state, SAR register and output-register update logic.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would otherwise infer a latch.
        state_d = state_q;
        trial_d = trial_q;
        idx_d   = idx_q;
        vin_s_d = vin_s_q;
        q_d     = Q;
        busy_d  = BUSY;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (START) begin
                    vin_s_d = VIN;
                    trial_d = N'(1) << (N - 1);
                    idx_d   = IDX_MSB;
                    busy_d  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                if (idx_q != '0) begin
                    trial_d = (keep ? trial_q : (trial_q & ~idx_bit)) | (idx_bit >> 1);
                    idx_d   = idx_q - IW'(1);
                end else begin
                    q_d     = keep ? trial_q : (trial_q & ~N'(1));
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any conversion and clears the result.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: all state, including the held real voltage, is reset here so
        // an aborted conversion leaves nothing stale behind.
        if (RST) begin
            state_q <= IDLE;
            trial_q <= '0;
            idx_q   <= IDX_MSB;
            vin_s_q <= 0.0;
            Q       <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register sees pre-edge values.
            state_q <= state_d;
            trial_q <= trial_d;
            idx_q   <= idx_d;
            vin_s_q <= vin_s_d;
            Q       <= q_d;
            BUSY    <= busy_d;
            DONE    <= done_d;
        end
    end

`ifndef SYNTHESIS
    int unsigned busy_cnt;

    // Length of the current BUSY run, checked when DONE appears.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy_cnt <= 0;
        end else if (BUSY) begin
            busy_cnt <= busy_cnt + 1;
        end else begin
            busy_cnt <= 0;
        end
    end

    // Protocol and result-range invariants.
    always @(posedge CLK) begin
        if (!RST) begin
            assert (!(BUSY && DONE));
            if (DONE) begin
                assert ((code_to_volt(int'(Q), N, VREF) <= vin_s_q) || (Q == '0));
                assert ((vin_s_q < code_to_volt(int'(Q) + 1, N, VREF)) || (Q == '1));
                assert (busy_cnt == N);
            end
        end
    end
`endif

endmodule

// File: tb/tb_sar_adc.sv
// Scoreboard bench for sar_adc (N=3, VREF=1.0): expected codes are queued when
// START is driven and compared by a monitor whenever DONE is seen.
`timescale 1ns/1ps
module tb_sar_adc;
    import sar_adc_pkg::*;

    localparam int  NB    = 3;
    localparam real VR    = 1.0;
    localparam real DELTA = VR / 8.0;

    logic          clk;
    logic          rst;
    logic          start;
    real           vin;
    logic [NB-1:0] q;
    logic          busy;
    logic          done;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    logic [NB-1:0] sb[$];

    sar_adc #(.N(NB), .VREF(VR)) dut (
        .CLK   (clk),
        .RST   (rst),
        .START (start),
        .VIN   (vin),
        .Q     (q),
        .BUSY  (busy),
        .DONE  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference result: clamp(floor(v/delta), 0, 7).
    function automatic logic [NB-1:0] exp_code(input real v);
        real k;
        if (v < 0.0) return '0;
        k = $floor(v / DELTA);
        if (k > 7.0) return 3'd7;
        return 3'(int'(k));
    endfunction

    // Scoreboard monitor: every DONE must match the oldest queued code.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            done_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got Q=%0d with empty scoreboard", q);
            end else begin
                logic [NB-1:0] e;
                e = sb.pop_front();
                if (q !== e) begin
                    errors++;
                    $display("FAIL scoreboard_q: got %0d want %0d", q, e);
                end
            end
        end
    end

    task automatic start_conv(input real v, input bit expect_result);
        vin   = v;
        start = 1'b1;
        if (expect_result) sb.push_back(exp_code(v));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 12) begin
            @(negedge clk);
            cycles++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: DONE got 0 want 1", name);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        vin   = 0.0;
        repeat (2) @(negedge clk);
        checks++;
        if (q !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || dut.trial_q !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got q=%0d busy=%b done=%b trial=%b want 0 0 0 000",
                     q, busy, done, dut.trial_q);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [NB-1:0] exp_trial [3];
        exp_trial = '{3'b100, 3'b110, 3'b101};
        start_conv(0.5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || dut.trial_q !== exp_trial[i]) begin
                errors++;
                $display("FAIL basic_conv%0d: got busy=%b done=%b trial=%b want 1 0 %b",
                         i, busy, done, dut.trial_q, exp_trial[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_cycle: got done=%b busy=%b want 1 0", done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || q !== 3'd4) begin
            errors++;
            $display("FAIL basic_hold: got done=%b q=%0d want 0 4", done, q);
        end
    endtask

    task automatic test_codes();
        real vals [10];
        int  cyc;
        vals = '{0.3, 0.125, 0.124, 1.2, 0.999, -0.2, 0.0, 1.0, 0.875, 0.874};
        for (int i = 0; i < 10; i++) begin
            start_conv(vals[i], 1'b1);
            wait_done("codes", cyc);
            checks++;
            if (cyc != 3) begin
                errors++;
                $display("FAIL codes_latency vin=%f: got %0d want 3", vals[i], cyc);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hold();
        int d0;
        int cyc;
        d0    = done_cnt;
        vin   = 0.5;
        start = 1'b1;
        sb.push_back(3'd4);
        @(negedge clk);
        vin   = 0.0;
        @(negedge clk);
        start = 1'b0;
        wait_done("hold", cyc);
        checks++;
        if (cyc != 2) begin
            errors++;
            $display("FAIL hold_latency: got %0d want 2", cyc);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL hold_done_count: got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_reset_abort();
        int d0;
        int cyc;
        start_conv(0.9, 1'b1);
        wait_done("pre_abort", cyc);
        @(negedge clk);
        start_conv(0.5, 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (q !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_immediate: got q=%0d busy=%b done=%b want 0 0 0", q, busy, done);
        end
        d0 = done_cnt;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: got dones=%0d busy=%b want 0 0", done_cnt - d0, busy);
        end
        start_conv(0.3, 1'b1);
        wait_done("post_abort", cyc);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc;
        start_conv(code_to_volt(0, NB, VR), 1'b1);
        for (int k = 1; k <= 8; k++) begin
            wait_done("loopback", cyc);
            if (k < 8) begin
                start_conv(code_to_volt(k, NB, VR), 1'b1);
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_handover code %0d: got busy=%b done=%b want 1 0",
                             k, busy, done);
                end
            end
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_codes();
        test_hold();
        test_reset_abort();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sar_adc.md
Name: sar_adc

Overview:
- Clocked successive-approximation ADC model in SV-RNM. It is the reverse direction of the team's real-valued DAC model: it converts a real analog input VIN into an n-bit code Q.
- The block samples VIN on a START request, then resolves one bit per clock from MSB to LSB. The trial comparison uses an internal code-to-voltage model with the same transfer function as the DAC (code * VREF/2^N).
- Q is usable as a DAC input, so a DAC plus sar_adc pair forms a loopback bench.

Parameters:
- N, 3, number of output bits.
- VREF, 1.0 (real), full-scale reference; delta = VREF / 2.0**N.

Ports:
- CLK  input  1  conversion clock, rising edge.
- RST  input  1  asynchronous active-high reset.
- START  input  1  conversion request; sampled only in IDLE.
- VIN  input  real  analog input voltage.
- Q  output  N  last completed conversion result (registered).
- BUSY  output  1  high while a conversion is in progress.
- DONE  output  1  one-cycle pulse when Q is updated.

Behaviour:
- Reset: one clock, CLK. RST is asynchronous and active-high. While RST is high: state=IDLE, Q='0, BUSY=0, DONE=0, sampled voltage=0.0, trial code='0, bit index=N-1.
- States: IDLE, CONV.
- IDLE:
  - DONE is low except in the single cycle after the final CONV edge.
  - On a rising edge with START=1: vin_s<=VIN; trial<=(1<<(N-1)); idx<=N-1; BUSY<=1; go to CONV.
- CONV, at each edge:
  - keep = (vin_s >= trial*delta).
  - If idx>0: trial<=(keep ? trial : trial & ~(1<<idx)) | (1<<(idx-1)); idx<=idx-1.
  - If idx==0: Q<=(keep ? trial : trial & ~1); DONE<=1; BUSY<=0; go to IDLE.
- Latency:
  - Exactly N CONV edges after the START edge.
  - DONE is high for exactly one cycle and Q is valid from that cycle onward.
  - Q holds its value until the next DONE.
- Result rule: Q = clamp(floor(vin_s/delta), 0, 2^N-1). All comparisons are done in real arithmetic, with no rounding.
- Boundaries:
  - vin_s<0.0 gives Q='0.
  - vin_s>=VREF gives Q='1.
  - vin_s exactly equal to k*delta gives Q=k.
- VIN changes during CONV are ignored; only vin_s is used.
- START while BUSY is ignored; it is neither queued nor able to restart the conversion.
- Back-to-back: START high in the DONE cycle is accepted at the next edge. DONE falls and BUSY rises on that same edge.
- RST mid-conversion aborts immediately to the reset values. The previous Q is cleared to '0.
- Invariants (assertions):
  - BUSY and DONE are never both 1.
  - DONE implies (Q*delta <= vin_s || Q=='0) && (vin_s < (Q+1)*delta || Q=='1).
  - BUSY remains 1 for exactly N cycles per accepted START.
- Formal build (FORMAL defined): real arithmetic is expressed with continuous assigns and always_comb, consistent with the DAC model. All state is held in always_ff with the async reset.

Decomposition:
- Package sar_adc_pkg:
  - typedef enum logic {IDLE, CONV} sar_state_t.
  - function real code_to_volt(input int code, input int n, input real vref), returning code*vref/2.0**n. This function is shared with the DAC so both use one transfer function.
- Sub-module sar_trial_cmp: combinational; inputs trial code and vin_s, output keep. It isolates the real-valued comparator so it can be verified on its own.
- FSM, SAR register and output registers live in sar_adc.

Test Plan (N=3, VREF=1.0, delta=0.125):
- VIN=0.5, START pulse -> BUSY high 3 cycles; DONE one cycle later with Q=3'b100. Trial sequence 100, 110, 101 observed.
- VIN=0.3 -> Q=2. VIN=0.125 -> Q=1 (exact boundary). VIN=0.124 -> Q=0.
- VIN=1.2 -> Q=7. VIN=0.999 -> Q=7. VIN=-0.2 -> Q=0.
- VIN=0.5 at START, then VIN changed to 0.0 on the next cycle -> Q=4 (sampled value held). A second START during BUSY is ignored, with still exactly one DONE.
- RST asserted in the second CONV cycle, between edges -> Q, BUSY and DONE go to 0 immediately, with no DONE after release. A new START converts normally.
- Loopback: sweep Q_in over 0..7 through the DAC model into VIN -> ADC Q == Q_in for every code, with back-to-back STARTs issued in the DONE cycles.
